sub_serial: RTL and testbench

SUB_SERIAL -- requirements
Module: sub_serial

---
 rtl/sub_serial.sv | 106 ++++++++++
 tb/tb_sub_serial.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Optional signed-overflow flag ovf is built only when SUB_OVF_EN is defined.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshake: en is a level start request accepted only in IDLE; results are
    // valid while done=1, and done is held until en is seen low, so a held en
    // never retriggers.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         st;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             brw;
    logic [CW-1:0]    count;

    logic d;
    logic brw_next;
    logic last;

    assign d        = a_reg[0] ^ b_reg[0] ^ brw;
    assign brw_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw);
    assign last     = (count == CW'(WIDTH - 1));

    assign state = st;
    assign busy  = (st == SUB);
    assign done  = (st == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            brw    <= 1'b0;
            count  <= '0;
            out    <= '0;
            borrow <= 1'b0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (en) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        brw    <= 1'b0;
                        count  <= '0;
                        out    <= '0;
                        borrow <= 1'b0;
`ifdef SUB_OVF_EN
                        ovf    <= 1'b0;
`endif
                        st     <= SUB;
                    end
                end
                SUB: begin
                    out   <= {d, out[WIDTH-1:1]};
                    brw   <= brw_next;
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (last) begin
                        // Borrow into the MSB vs. out of it gives signed overflow.
                        borrow <= brw_next;
`ifdef SUB_OVF_EN
                        ovf    <= brw ^ brw_next;
`endif
                        st     <= DONE;
                    end
                end
                DONE: begin
                    if (!en) begin
                        st <= IDLE;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed corner cases plus random operands,
// results checked by a done-triggered monitor against an arithmetic model queue.
module tb_sub_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] out;
    logic         borrow;
    logic         busy;
    logic         done;
    logic [1:0]   state;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;

    logic [W+1:0] exp_q[$];

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a_in),
        .b      (b_in),
        .out    (out),
        .borrow (borrow),
        .busy   (busy),
        .done   (done),
        .state  (state)
`ifdef SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

`ifndef SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands. Packed as {ovf, borrow, out}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint half;
        longint full;
        longint sx;
        longint sy;
        longint sd;
        longint diff;
        logic   v;
        logic   bw;
        half = longint'(1) << (W - 1);
        full = half * 2;
        diff = longint'(x) - longint'(y);
        if (diff < 0) diff = diff + full;
        bw = (x < y);
        sx = (longint'(x) >= half) ? longint'(x) - full : longint'(x);
        sy = (longint'(y) >= half) ? longint'(y) - full : longint'(y);
        sd = sx - sy;
        v  = (sd < -half) || (sd > half - 1);
        return {v, bw, W'(diff)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        logic [W+1:0] e;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("out", 64'(out), 64'(e[W-1:0]));
                check("borrow", 64'(borrow), 64'(e[W]));
`ifdef SUB_OVF_EN
                check("ovf", 64'(ovf), 64'(e[W+1]));
`endif
            end
        end
        done_prev <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        a_in = x;
        b_in = y;
        en   = 1'b1;
        if (push) exp_q.push_back(model(x, y));
        @(posedge clk);
        #1;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Waits for done (bounded); optionally scrambles a/b while busy.
    task automatic wait_done(input bit scramble);
        int edges;
        edges = 1;
        while (!done && edges < 60) begin
            if (scramble) begin
                a_in = W'($urandom());
                b_in = W'($urandom());
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency_edges", 64'(edges), 64'(W + 1));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit scramble);
        logic [W+1:0] e;
        e = model(x, y);
        start_op(x, y, 1'b1);
        en = 1'b0;
        wait_done(scramble);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("idle_after_done", 64'(state), 64'd0);
        check("out_hold_idle", 64'(out), 64'(e[W-1:0]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W+1:0] e;
        #1 rst = 1'b1;
        #3;
        check("rst_out", 64'(out), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        start_op(8'hAA, 8'h55, 1'b0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out", 64'(out), 64'd0);
        check("abort_state", 64'(state), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_borrow", 64'(borrow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h01, 1'b0);

        // Held en must not retrigger from DONE.
        e = model(8'h3C, 8'h11);
        start_op(8'h3C, 8'h11, 1'b1);
        wait_done(1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_state", 64'(state), 64'd2);
            check("hold_out", 64'(out), 64'(e[W-1:0]));
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release", 64'(state), 64'd0);
        start_op(8'h21, 8'h42, 1'b1);
        en = 1'b0;
        wait_done(1'b0);
        @(negedge clk);
        @(posedge clk);

        // Inputs change while busy; result must use captured operands.
        run_op(8'h64, 8'h32, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom()), W'($urandom()), ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
